// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store unit.
// Load/store has priority; a starvation counter forces fetch through after STARVE_LIMIT losses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_rsp_valid,
    output logic [DATA_WIDTH-1:0]     if_rsp_rdata,
    output logic                      if_rsp_err,
    input  logic                      ls_req_valid,
    output logic                      ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]     ls_addr,
    input  logic                      ls_we,
    input  logic [DATA_WIDTH/8-1:0]   ls_be,
    input  logic [DATA_WIDTH-1:0]     ls_wdata,
    output logic                      ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]     ls_rsp_rdata,
    output logic                      ls_rsp_err,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [31:0]               conflict_cnt
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = '1;

    logic [SW-1:0] starve_cnt;
    logic          force_if;
    logic          if_gnt;
    logic          ls_gnt;
    logic          if_oor;
    logic          ls_oor;
    logic          rsp_if;
    logic          rsp_ls;
    logic          rsp_err;
    logic          rsp_we;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

    assign force_if = (STARVE_LIMIT != 0) &&
                      ({{(32-SW){1'b0}}, starve_cnt} >= 32'(STARVE_LIMIT));

    assign if_oor = |if_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
    assign ls_oor = |ls_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    // Grants are gated by arst_n so readies and memory strobes read 0 while reset is held.
    assign ls_gnt = arst_n && ls_req_valid && !(if_req_valid && force_if);
    assign if_gnt = arst_n && if_req_valid && !ls_gnt;

    assign if_req_ready = if_gnt;
    assign ls_req_ready = ls_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_en   = !ls_oor;
            mem_addr = ls_addr[MEM_ADDR_WIDTH+1:2];
            if (ls_we && !ls_oor) begin
                mem_we = ls_be;
            end
        end else if (if_gnt) begin
            mem_en   = !if_oor;
            mem_addr = if_addr[MEM_ADDR_WIDTH+1:2];
        end
        if (arst_n) begin
            mem_wdata = ls_wdata;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt   <= '0;
            conflict_cnt <= '0;
            rsp_if       <= 1'b0;
            rsp_ls       <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_we       <= 1'b0;
        end else begin
            if (!if_req_valid || if_gnt) begin
                starve_cnt <= '0;
            end else if (ls_gnt && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (if_req_valid && ls_req_valid && conflict_cnt != 32'hFFFF_FFFF) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            rsp_if  <= if_gnt;
            rsp_ls  <= ls_gnt;
            rsp_err <= (if_gnt && if_oor) || (ls_gnt && ls_oor);
            rsp_we  <= ls_gnt && ls_we;
        end
    end

    // Memory read data lines up with the tags registered at the grant edge.
    assign if_rsp_valid = rsp_if;
    assign if_rsp_err   = rsp_if && rsp_err;
    assign if_rsp_rdata = (rsp_if && !rsp_err) ? mem_rdata : '0;

    assign ls_rsp_valid = rsp_ls;
    assign ls_rsp_err   = rsp_ls && rsp_err;
    assign ls_rsp_rdata = (rsp_ls && !rsp_err && !rsp_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table for grant/issue, scoreboard queues for responses.
module tb_mem_port_arbiter;

    logic        clk;
    logic        arst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_wdata;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;
    logic        ls_rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] conflict_cnt;

    mem_port_arbiter dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_rdata (if_rsp_rdata),
        .if_rsp_err   (if_rsp_err),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_addr      (ls_addr),
        .ls_we        (ls_we),
        .ls_be        (ls_be),
        .ls_wdata     (ls_wdata),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_rdata (ls_rsp_rdata),
        .ls_rsp_err   (ls_rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic        if_v;
        logic [31:0] if_a;
        logic        ls_v;
        logic [31:0] ls_a;
        logic        ls_w;
        logic [3:0]  ls_b;
        logic [31:0] ls_d;
        logic        e_if;
        logic        e_ls;
        logic        e_en;
        logic [3:0]  e_we;
        logic [7:0]  e_addr;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    rsp_t        if_q [$];
    rsp_t        ls_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          conf_model = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic oor(input logic [31:0] a);
        return a[31:10] != 22'd0;
    endfunction

    function automatic vec_t mk(input logic if_v, input logic [31:0] if_a, input logic ls_v,
                                input logic [31:0] ls_a, input logic ls_w, input logic [3:0] ls_b,
                                input logic [31:0] ls_d, input logic e_if, input logic e_ls,
                                input logic e_en, input logic [3:0] e_we, input logic [7:0] e_addr);
        vec_t v;
        v.if_v = if_v; v.if_a = if_a; v.ls_v = ls_v; v.ls_a = ls_a; v.ls_w = ls_w;
        v.ls_b = ls_b; v.ls_d = ls_d; v.e_if = e_if; v.e_ls = e_ls; v.e_en = e_en;
        v.e_we = e_we; v.e_addr = e_addr;
        return v;
    endfunction

    // Response checker: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        rsp_t r;
        if (if_rsp_valid) begin
            if (if_q.size() == 0) begin
                chk("if_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                r = if_q.pop_front();
                chk("if_rsp_rdata", if_rsp_rdata, r.d);
                chk("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, r.e});
            end
        end else begin
            chk("if_rsp_idle", {if_rsp_rdata[30:0], if_rsp_err}, 32'd0);
        end
        if (ls_rsp_valid) begin
            if (ls_q.size() == 0) begin
                chk("ls_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                r = ls_q.pop_front();
                chk("ls_rsp_rdata", ls_rsp_rdata, r.d);
                chk("ls_rsp_err", {31'd0, ls_rsp_err}, {31'd0, r.e});
            end
        end else begin
            chk("ls_rsp_idle", {ls_rsp_rdata[30:0], ls_rsp_err}, 32'd0);
        end
    end

    task automatic apply(input vec_t v, input string nm);
        rsp_t r;
        logic [7:0] w;
        @(negedge clk);
        if_req_valid = v.if_v;
        if_addr      = v.if_a;
        ls_req_valid = v.ls_v;
        ls_addr      = v.ls_a;
        ls_we        = v.ls_w;
        ls_be        = v.ls_b;
        ls_wdata     = v.ls_d;
        #2;
        chk({nm, "/if_ready"}, {31'd0, if_req_ready}, {31'd0, v.e_if});
        chk({nm, "/ls_ready"}, {31'd0, ls_req_ready}, {31'd0, v.e_ls});
        chk({nm, "/mem_en"}, {31'd0, mem_en}, {31'd0, v.e_en});
        chk({nm, "/mem_we"}, {28'd0, mem_we}, {28'd0, v.e_we});
        if (v.e_en) chk({nm, "/mem_addr"}, {24'd0, mem_addr}, {24'd0, v.e_addr});
        if (v.e_ls && v.ls_w && v.e_en) chk({nm, "/mem_wdata"}, mem_wdata, v.ls_d);
        chk({nm, "/conflict_cnt"}, conflict_cnt, conf_model);
        if (v.if_v && v.ls_v) conf_model++;
        if (v.e_if) begin
            w = v.if_a[9:2];
            r.e = oor(v.if_a);
            r.d = r.e ? 32'd0 : ref_mem[w];
            if_q.push_back(r);
        end
        if (v.e_ls) begin
            w = v.ls_a[9:2];
            r.e = oor(v.ls_a);
            r.d = (r.e || v.ls_w) ? 32'd0 : ref_mem[w];
            if (v.ls_w && !r.e) begin
                for (int b = 0; b < 4; b++) begin
                    if (v.ls_b[b]) ref_mem[w][8*b +: 8] = v.ls_d[8*b +: 8];
                end
            end
            ls_q.push_back(r);
        end
    endtask

    initial begin
        vec_t vt [$];
        vec_t idle;
        vec_t v;

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = {16'hC0DE, 8'(i), 8'(~i)};
            ref_mem[i] = {16'hC0DE, 8'(i), 8'(~i)};
        end
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);

        arst_n = 1'b0;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_be = '0; ls_wdata = '0;
        #3;
        chk("rst/mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst/rsp_valid", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        chk("rst/conflict_cnt", conflict_cnt, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        vt.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 8'd4));
        vt.push_back(mk(0, 0, 1, 32'h20, 0, 0, 0, 0, 1, 1, 4'h0, 8'd8));
        vt.push_back(mk(0, 0, 1, 32'h8, 1, 4'b0011, 32'hDEADBEEF, 0, 1, 1, 4'b0011, 8'd2));
        vt.push_back(mk(0, 0, 1, 32'h8, 0, 0, 0, 0, 1, 1, 4'h0, 8'd2));
        vt.push_back(mk(1, 32'h40, 1, 32'hC, 0, 0, 0, 0, 1, 1, 4'h0, 8'd3));
        vt.push_back(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 1, 0, 4'h0, 8'd0));
        vt.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0, 8'd0));
        vt.push_back(mk(1, 32'h13, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 8'd4));
        vt.push_back(mk(0, 0, 1, 32'h404, 1, 4'hF, 32'h55AA55AA, 0, 1, 0, 4'h0, 8'd0));
        vt.push_back(mk(0, 0, 1, 32'hFC, 1, 4'b1100, 32'h12345678, 0, 1, 1, 4'b1100, 8'd63));
        vt.push_back(mk(1, 32'hFE, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 8'd63));
        foreach (vt[i]) begin
            apply(vt[i], $sformatf("vec%0d", i));
            apply(idle, $sformatf("idle%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            apply(mk(1, 32'(4 * i), 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 8'(i)), $sformatf("b2b%0d", i));
        end
        apply(idle, "b2b_idle");
        chk("b2b/if_q_drained", if_q.size(), 32'd0);

        for (int k = 0; k < 10; k++) begin
            v = (k % 5 != 4) ? mk(1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 1, 1, 4'h0, 8'h20)
                             : mk(1, 32'h40, 1, 32'h80, 0, 0, 0, 1, 0, 1, 4'h0, 8'h10);
            apply(v, $sformatf("starve%0d", k));
        end
        apply(idle, "starve_idle");

        apply(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 8'd0), "pre_rst");
        @(posedge clk);
        #1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        arst_n = 1'b0;
        if_q.delete();
        ls_q.delete();
        conf_model = 0;
        #1;
        chk("arst/readies", {30'd0, if_req_ready, ls_req_ready}, 32'd0);
        chk("arst/rsp_valid", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        chk("arst/mem_en_we", {27'd0, mem_en, mem_we}, 32'd0);
        chk("arst/mem_wdata", mem_wdata, 32'd0);
        chk("arst/conflict_cnt", conflict_cnt, 32'd0);
        chk("arst/starve_cnt", 32'(dut.starve_cnt), 32'd0);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        apply(idle, "post_rst0");
        apply(idle, "post_rst1");
        for (int k = 0; k < 5; k++) begin
            v = (k != 4) ? mk(1, 32'h44, 1, 32'h84, 0, 0, 0, 0, 1, 1, 4'h0, 8'h21)
                         : mk(1, 32'h44, 1, 32'h84, 0, 0, 0, 1, 0, 1, 4'h0, 8'h11);
            apply(v, $sformatf("post_rst_starve%0d", k));
        end
        apply(idle, "end0");
        apply(idle, "end1");
        chk("end/if_q_empty", if_q.size(), 32'd0);
        chk("end/ls_q_empty", ls_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
